// File: rtl/cpu_pkg.sv
// Shared definitions for the bit-serial CPU front end.
//   state_t   : sequencer FSM encoding
//   OP_*      : opcode constants (OP_NOP retires without touching the datapath)
//   INSTR_W   : fetched instruction width (opcode + operand)
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_W   = 4;
    localparam int OPD_W   = INSTR_W - OPC_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_HI = 3'd1,
        LOAD     = 3'd2,
        EXECUTE  = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND = 4'h3;
    localparam logic [OPC_W-1:0] OP_OR  = 4'h4;
    localparam logic [OPC_W-1:0] OP_XOR = 4'h5;

    function automatic logic is_nop(input logic [OPC_W-1:0] op);
        return op == OP_NOP;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Push-button synchroniser and rising-edge detector.
//   clk, rst_n : system clock, async active-low reset
//   btn_level  : raw asynchronous button level (active-high)
//   btn_edge   : one-cycle pulse per rising edge of the synchronised level
// A held button yields a single pulse; btn_prev remembers the last
// synchronised level so the pulse drops after one cycle.
module btn_edge_sync
    import cpu_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    output logic btn_edge
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   btn_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= '0;
            btn_prev <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], btn_level};
            btn_prev <= sync[SYNC_STAGES-1];
        end
    end

    assign btn_edge = sync[SYNC_STAGES-1] & ~btn_prev;

endmodule

// File: rtl/bitserial_seq_ctrl.sv
// Front-end sequencer for the bit-serial CPU datapath.
//   clk, rst_n : system clock, async active-low reset
//   btn_level  : raw operator push button
//   sw         : DIP-switch byte, captured only on an accepted press
//   opcode     : latched opcode (first press, sw[3:0])
//   operand    : latched operand ({second press sw, first press sw[7:4]})
//   le         : one-cycle parallel load of the shift registers
//   shift_en   : shift serial registers one bit (EXECUTE)
//   ae         : ALU accumulate enable (EXECUTE)
//   bit_idx    : serial bit index, LSB first
//   last_bit   : final EXECUTE cycle
//   busy       : LOAD / EXECUTE / DONE
//   done       : one-cycle retire pulse
// All outputs are registered and valid in the same cycle as the state
// they belong to, so they are set on the transition into that state.
module bitserial_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      btn_level,
    input  logic [7:0]                sw,
    output logic [3:0]                opcode,
    output logic [11:0]               operand,
    output logic                      le,
    output logic                      shift_en,
    output logic                      ae,
    output logic [$clog2(DATA_W)-1:0] bit_idx,
    output logic                      last_bit,
    output logic                      busy,
    output logic                      done
);

    localparam int                IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);

    logic   btn_edge;
    state_t state;

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_btn (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_level (btn_level),
        .btn_edge  (btn_edge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            opcode   <= '0;
            operand  <= '0;
            le       <= 1'b0;
            shift_en <= 1'b0;
            ae       <= 1'b0;
            bit_idx  <= '0;
            last_bit <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            le   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_edge) begin
                        opcode       <= sw[3:0];
                        operand[3:0] <= sw[7:4];
                        state        <= FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    if (btn_edge) begin
                        operand[11:4] <= sw;
                        le            <= 1'b1;
                        busy          <= 1'b1;
                        bit_idx       <= '0;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    if (is_nop(opcode)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        shift_en <= 1'b1;
                        ae       <= 1'b1;
                        bit_idx  <= '0;
                        last_bit <= 1'b0;
                        state    <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    if (bit_idx == LAST_IDX) begin
                        shift_en <= 1'b0;
                        ae       <= 1'b0;
                        last_bit <= 1'b0;
                        bit_idx  <= '0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        bit_idx  <= bit_idx + 1'b1;
                        // flag goes high together with the final index
                        last_bit <= (bit_idx + 1'b1) == LAST_IDX;
                    end
                end
                DONE: begin
                    // presses seen here are dropped: IDLE only reacts to a new edge
                    busy    <= 1'b0;
                    bit_idx <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitserial_seq_ctrl.sv
module tb_bitserial_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_level = 1'b0;
    logic [7:0]  sw = 8'h00;
    logic [3:0]  opcode;
    logic [11:0] operand;
    logic        le, shift_en, ae, last_bit, busy, done;
    logic [2:0]  bit_idx;

    int pass = 0;
    int total = 0;

    // event log, sampled 1 time unit after each rising edge
    int cyc = 0;
    int le_cnt, sh_cnt, lb_cnt, done_cnt, ae_bad;
    int le_cyc, lb_cyc, done_cyc, lb_idx;
    int idx_q[$];

    bitserial_seq_ctrl #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .sw(sw),
        .opcode(opcode), .operand(operand), .le(le), .shift_en(shift_en),
        .ae(ae), .bit_idx(bit_idx), .last_bit(last_bit), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (le) begin le_cnt++; le_cyc = cyc; end
        if (shift_en) begin
            sh_cnt++;
            idx_q.push_back(int'(bit_idx));
            if (!ae) ae_bad++;
        end
        if (last_bit) begin lb_cnt++; lb_idx = int'(bit_idx); lb_cyc = cyc; end
        if (done) begin done_cnt++; done_cyc = cyc; end
    end

    task automatic clear_log();
        le_cnt = 0; sh_cnt = 0; lb_cnt = 0; done_cnt = 0; ae_bad = 0;
        le_cyc = -100; lb_cyc = -100; done_cyc = -100; lb_idx = -1;
        idx_q.delete();
    endtask

    task automatic press(input logic [7:0] v, input int hold);
        @(negedge clk);
        sw = v;
        btn_level = 1'b1;
        repeat (hold) @(negedge clk);
        btn_level = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (done_cnt > 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({opcode, operand, le, shift_en, ae, bit_idx, last_bit, busy, done} !== '0)
            $display("FAIL reset_outputs got %h exp 0", {opcode, operand, le, shift_en, ae, bit_idx, last_bit, busy, done}); else pass++;
        rst_n = 1'b1;
        clear_log();
        repeat (20) @(negedge clk);
        total++; if ({opcode, operand, le, shift_en, ae, bit_idx, last_bit, busy, done} !== '0)
            $display("FAIL idle_outputs got %h exp 0", {opcode, operand, le, shift_en, ae, bit_idx, last_bit, busy, done}); else pass++;
        total++; if (le_cnt + sh_cnt + done_cnt !== 0)
            $display("FAIL idle_activity got %0d exp 0", le_cnt + sh_cnt + done_cnt); else pass++;
    endtask

    // instruction 0x2/0xA75, with a press injected during EXECUTE
    task automatic test_execute();
        clear_log();
        press(8'h52, 3);
        total++; if (opcode !== 4'h2) $display("FAIL t2_opcode got %h exp 2", opcode); else pass++;
        total++; if (busy !== 1'b0 || le_cnt !== 0) $display("FAIL t2_fetch_hi busy %b le %0d exp 0 0", busy, le_cnt); else pass++;
        sw = 8'h3C;
        repeat (2) @(negedge clk);
        total++; if (operand[3:0] !== 4'h5) $display("FAIL t2_sw_ignored got %h exp 5", operand[3:0]); else pass++;
        press(8'hA7, 3);
        // button pulsed while EXECUTE is running
        btn_level = 1'b1;
        repeat (3) @(negedge clk);
        btn_level = 1'b0;
        wait_done();
        total++; if (operand !== 12'hA75) $display("FAIL t2_operand got %h exp a75", operand); else pass++;
        total++; if (le_cnt !== 1) $display("FAIL t2_le_count got %0d exp 1", le_cnt); else pass++;
        total++; if (sh_cnt !== 8) $display("FAIL t2_shift_count got %0d exp 8", sh_cnt); else pass++;
        total++; if (ae_bad !== 0) $display("FAIL t2_ae_with_shift got %0d exp 0", ae_bad); else pass++;
        begin
            bit ok = (idx_q.size() == 8);
            for (int i = 0; i < idx_q.size() && i < 8; i++) if (idx_q[i] != i) ok = 0;
            total++; if (!ok) $display("FAIL t2_bit_idx_seq got size %0d exp 0..7", idx_q.size()); else pass++;
        end
        total++; if (lb_cnt !== 1 || lb_idx !== 7) $display("FAIL t2_last_bit got cnt %0d idx %0d exp 1 7", lb_cnt, lb_idx); else pass++;
        total++; if (done_cnt !== 1 || done_cyc - lb_cyc !== 1) $display("FAIL t2_done_after_last got cnt %0d dt %0d exp 1 1", done_cnt, done_cyc - lb_cyc); else pass++;
        total++; if (done_cyc - le_cyc !== 9) $display("FAIL t2_le_to_done got %0d exp 9", done_cyc - le_cyc); else pass++;
        total++; if (busy !== 1'b0) $display("FAIL t2_busy_after got %b exp 0", busy); else pass++;
        // state must be IDLE: a single press captures the low byte only
        clear_log();
        press(8'h01, 3);
        repeat (3) @(negedge clk);
        total++; if (opcode !== 4'h1 || le_cnt !== 0) $display("FAIL t5_back_in_idle got op %h le %0d exp 1 0", opcode, le_cnt); else pass++;
        press(8'hFF, 3);
        wait_done();
        total++; if (operand !== 12'hFF0 || done_cnt !== 1) $display("FAIL t5_next_instr got %h done %0d exp ff0 1", operand, done_cnt); else pass++;
    endtask

    task automatic test_nop();
        clear_log();
        press(8'h30, 3);
        press(8'h00, 3);
        wait_done();
        total++; if (opcode !== 4'h0 || operand !== 12'h003) $display("FAIL t3_instr got %h %h exp 0 003", opcode, operand); else pass++;
        total++; if (le_cnt !== 1 || done_cnt !== 1 || done_cyc - le_cyc !== 1) $display("FAIL t3_le_to_done got le %0d done %0d dt %0d exp 1 1 1", le_cnt, done_cnt, done_cyc - le_cyc); else pass++;
        total++; if (sh_cnt !== 0 || lb_cnt !== 0) $display("FAIL t3_no_shift got sh %0d lb %0d exp 0 0", sh_cnt, lb_cnt); else pass++;
    endtask

    task automatic test_held();
        clear_log();
        press(8'h14, 50);
        total++; if (opcode !== 4'h4 || operand[3:0] !== 4'h1) $display("FAIL t4_capture got %h %h exp 4 1", opcode, operand[3:0]); else pass++;
        total++; if (le_cnt !== 0 || busy !== 1'b0) $display("FAIL t4_single_edge got le %0d busy %b exp 0 0", le_cnt, busy); else pass++;
        press(8'h9C, 3);
        wait_done();
        total++; if (operand !== 12'h9C1 || le_cnt !== 1 || sh_cnt !== 8) $display("FAIL t4_resume got %h le %0d sh %0d exp 9c1 1 8", operand, le_cnt, sh_cnt); else pass++;
    endtask

    task automatic test_reset_mid_exec();
        bit hit = 0;
        clear_log();
        press(8'h83, 3);
        @(negedge clk);
        sw = 8'h5E;
        btn_level = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (shift_en === 1'b1 && bit_idx === 3'd4) begin hit = 1; break; end
        end
        total++; if (!hit) $display("FAIL t6_reach_idx4 got timeout exp bit_idx 4"); else pass++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({opcode, operand, le, shift_en, ae, bit_idx, last_bit, busy, done} !== '0)
            $display("FAIL t6_async_reset got %h exp 0", {opcode, operand, le, shift_en, ae, bit_idx, last_bit, busy, done}); else pass++;
        btn_level = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_log();
        press(8'h45, 3);
        press(8'h3B, 3);
        wait_done();
        total++; if (opcode !== 4'h5 || operand !== 12'h3B4) $display("FAIL t6_refetch got %h %h exp 5 3b4", opcode, operand); else pass++;
        total++; if (sh_cnt !== 8 || done_cnt !== 1 || done_cyc - le_cyc !== 9) $display("FAIL t6_reexec got sh %0d done %0d dt %0d exp 8 1 9", sh_cnt, done_cnt, done_cyc - le_cyc); else pass++;
    endtask

    initial begin
        clear_log();
        test_reset();
        test_execute();
        test_nop();
        test_held();
        test_reset_mid_exec();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
